// File: rtl/bin_to_bcd_fmt.sv
// bin_to_bcd_fmt: sequential 27-bit binary to 8-digit packed BCD formatter.
// The value is converted with an iterative shift-and-add-3 engine.
// Leading zeros are optionally blanked, and out-of-range input is flagged.
// dsp_data[31:28] holds digit 7 and dsp_data[3:0] holds digit 0.
// Nibble 4'hF is the blank code.
module bin_to_bcd_fmt #(
   parameter bit LZ_BLANK = 1'b1
) (
   input  logic        bcd_clk,
   input  logic        bcd_rst,
   input  logic        start,
   input  logic [26:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [31:0] dsp_data
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FORMAT
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // [58:27] BCD digit field, [26:0] binary bits still to be shifted in
   logic [58:0] sr;
   logic [4:0]  iter;
   logic        ovf_pend;
   logic        last_iter;
   logic [31:0] bcd_adj;
   logic [31:0] bcd_raw;
   logic [31:0] bcd_blank;
   logic        leading;

   assign last_iter = (iter == 5'd26);
   assign busy      = (state != IDLE);
   assign bcd_raw   = sr[58:27];

   // State register
   always_ff @(posedge bcd_clk) begin
      if (bcd_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_iter) state_nxt = FORMAT;
         FORMAT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Add 3 to every BCD nibble >= 5 ahead of the shift
   always_comb begin
      bcd_adj = sr[58:27];
      for (int unsigned j = 0; j < 8; j++) begin
         if (sr[27 + 4*j +: 4] >= 4'd5) begin
            bcd_adj[4*j +: 4] = sr[27 + 4*j +: 4] + 4'd3;
         end
      end
   end

   // Blank leading zero digits from digit 7 down to digit 1; digit 0 is always shown
   always_comb begin
      bcd_blank = bcd_raw;
      leading   = 1'b1;
      for (int unsigned i = 0; i < 7; i++) begin
         if (leading && (bcd_raw[4*(7-i) +: 4] == 4'h0)) begin
            bcd_blank[4*(7-i) +: 4] = 4'hF;
         end else begin
            leading = 1'b0;
         end
      end
   end

   // Conversion datapath and registered outputs
   always_ff @(posedge bcd_clk) begin
      if (bcd_rst) begin
         sr       <= '0;
         iter     <= '0;
         ovf_pend <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         dsp_data <= '1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sr       <= {32'h0, bin_in};
                  iter     <= '0;
                  ovf_pend <= (bin_in > 27'd99_999_999);
               end
            end
            SHIFT: begin
               // The top BCD bit falls off the end; it only matters for overflow inputs, whose BCD is discarded
               sr   <= {bcd_adj, sr[26:0]} << 1;
               iter <= iter + 5'd1;
            end
            FORMAT: begin
               done <= 1'b1;
               if (ovf_pend) begin
                  dsp_data <= '1;
                  ovf      <= 1'b1;
               end else begin
                  ovf      <= 1'b0;
                  dsp_data <= LZ_BLANK ? bcd_blank : bcd_raw;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_fmt.sv
// Scoreboard bench for bin_to_bcd_fmt.
// Two instances share their inputs: one blanks leading zeros and one shows raw digits.
module tb_bin_to_bcd_fmt;

   logic        bcd_clk = 1'b0;
   logic        bcd_rst = 1'b1;
   logic        start   = 1'b0;
   logic [26:0] bin_in  = '0;
   logic        busy_a, done_a, ovf_a;
   logic [31:0] dsp_a;
   logic        busy_b, done_b, ovf_b;
   logic [31:0] dsp_b;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] blk;
      logic [31:0] raw;
      logic        ov;
      int          acc;
   } exp_t;

   exp_t q[$];

   bin_to_bcd_fmt #(.LZ_BLANK(1'b1)) dut_a (
      .bcd_clk(bcd_clk), .bcd_rst(bcd_rst), .start(start), .bin_in(bin_in),
      .busy(busy_a), .done(done_a), .ovf(ovf_a), .dsp_data(dsp_a)
   );

   bin_to_bcd_fmt #(.LZ_BLANK(1'b0)) dut_b (
      .bcd_clk(bcd_clk), .bcd_rst(bcd_rst), .start(start), .bin_in(bin_in),
      .busy(busy_b), .done(done_b), .ovf(ovf_b), .dsp_data(dsp_b)
   );

   always #5 bcd_clk = ~bcd_clk;

   always @(posedge bcd_clk) cyc <= cyc + 1;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pop and compare on every done; hold outputs stable otherwise
   logic        prev_rst = 1'b1;
   logic [31:0] last_a, last_b;
   logic        last_ova, last_ovb;
   exp_t        e;

   always @(negedge bcd_clk) begin
      if (done_a) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got dsp=%h expected no done (cycle %0d)", dsp_a, cyc);
         end else begin
            e = q.pop_front();
            chk32("dsp_blank", dsp_a, e.blk);
            chk32("dsp_raw", dsp_b, e.raw);
            chk1("ovf_a", ovf_a, e.ov);
            chk1("ovf_b", ovf_b, e.ov);
            chk32("latency", 32'(cyc - e.acc), 32'd28);
            chk1("done_b_aligned", done_b, 1'b1);
            chk1("busy_at_done", busy_a, 1'b0);
         end
      end else if (done_b) begin
         checks++;
         errors++;
         $display("FAIL done_b_alone: got 1 expected 0 (cycle %0d)", cyc);
      end else if (!prev_rst) begin
         chk32("hold_dsp_a", dsp_a, last_a);
         chk32("hold_dsp_b", dsp_b, last_b);
         chk1("hold_ovf_a", ovf_a, last_ova);
         chk1("hold_ovf_b", ovf_b, last_ovb);
      end
      last_a   = dsp_a;
      last_b   = dsp_b;
      last_ova = ovf_a;
      last_ovb = ovf_b;
      prev_rst = bcd_rst;
   end

   // Present one conversion request and record its expectation
   task automatic issue(input logic [26:0] v, input logic [31:0] blk,
                        input logic [31:0] raw, input logic ov);
      exp_t x;
      @(posedge bcd_clk);
      #1;
      start  = 1'b1;
      bin_in = v;
      @(posedge bcd_clk);
      #1;
      x.blk = blk;
      x.raw = raw;
      x.ov  = ov;
      x.acc = cyc;
      q.push_back(x);
      chk1("busy_after_accept", busy_a, 1'b1);
      start  = 1'b0;
      bin_in = 27'h5A5_A5A5;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge bcd_clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      repeat (2) @(posedge bcd_clk);
      #1;
      bcd_rst = 1'b0;
      chk32("rst_dsp_a", dsp_a, 32'hFFFF_FFFF);
      chk32("rst_dsp_b", dsp_b, 32'hFFFF_FFFF);
      chk1("rst_busy", busy_a, 1'b0);
      chk1("rst_done", done_a, 1'b0);
      chk1("rst_ovf", ovf_a, 1'b0);

      issue(27'd12_345_678, 32'h1234_5678, 32'h1234_5678, 1'b0);
      drain();
      issue(27'd0, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0);
      drain();
      issue(27'd4096, 32'hFFFF_4096, 32'h0000_4096, 1'b0);
      drain();

      // A start pulse during the conversion must be ignored
      issue(27'd10_000_001, 32'h1000_0001, 32'h1000_0001, 1'b0);
      repeat (10) @(posedge bcd_clk);
      #1;
      start  = 1'b1;
      bin_in = 27'd999;
      @(posedge bcd_clk);
      #1;
      start  = 1'b0;
      drain();
      repeat (5) @(posedge bcd_clk);

      issue(27'd305, 32'hFFFF_F305, 32'h0000_0305, 1'b0);
      drain();
      issue(27'd99_999_999, 32'h9999_9999, 32'h9999_9999, 1'b0);
      drain();
      issue(27'd100_000_000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      drain();
      issue(27'd7, 32'hFFFF_FFF7, 32'h0000_0007, 1'b0);
      drain();

      // start held high and bin_in = 500 + n; accepts at n = 0, 29 and 58
      @(posedge bcd_clk);
      #1;
      for (int n = 0; n <= 58; n++) begin
         bin_in = 27'(500 + n);
         start  = 1'b1;
         @(posedge bcd_clk);
         #1;
         if (n == 0)  q.push_back('{32'hFFFF_F500, 32'h0000_0500, 1'b0, cyc});
         if (n == 29) q.push_back('{32'hFFFF_F529, 32'h0000_0529, 1'b0, cyc});
         if (n == 58) q.push_back('{32'hFFFF_F558, 32'h0000_0558, 1'b0, cyc});
      end
      start = 1'b0;
      drain();

      // Reset sampled on SHIFT iteration 10 aborts the conversion
      issue(27'd12_345, 32'hFFF1_2345, 32'h0001_2345, 1'b0);
      repeat (9) @(posedge bcd_clk);
      #1;
      bcd_rst = 1'b1;
      @(posedge bcd_clk);
      #1;
      bcd_rst = 1'b0;
      q.delete();
      chk1("abort_busy", busy_a, 1'b0);
      chk1("abort_done", done_a, 1'b0);
      chk32("abort_dsp_a", dsp_a, 32'hFFFF_FFFF);
      chk32("abort_dsp_b", dsp_b, 32'hFFFF_FFFF);
      repeat (40) @(posedge bcd_clk);
      issue(27'd42, 32'hFFFF_FF42, 32'h0000_0042, 1'b0);
      drain();
      repeat (3) @(posedge bcd_clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bin_to_bcd_fmt.md
# bin_to_bcd_fmt

Sequential binary-to-BCD formatter that produces the 32-bit packed digit word consumed by the 8-digit seven-segment scan driver. It sits upstream of that driver. It accepts a 27-bit unsigned value on a start/busy/done handshake and converts it with an iterative shift-and-add-3 (double-dabble) engine. It then blanks leading zeros and flags out-of-range input. Digit 7 (most significant) is packed in dsp_data[31:28] and digit 0 in dsp_data[3:0]; nibble 4'hF is the blank code.

## Interface
- LZ_BLANK, 1: 1 = replace leading zero digits with 4'hF; 0 = show all 8 digits including leading zeros.
- bcd_clk  input  1  system clock; all state on rising edge.
- bcd_rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only when busy = 0.
- bin_in  input  27  unsigned binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; dsp_data/ovf valid and updated on the same edge.
- ovf  output  1  high when the last accepted bin_in exceeded 99_999_999; held until the next done.
- dsp_data  output  32  packed BCD digits; held stable between done pulses.

## Operation
- States: IDLE, SHIFT, FORMAT.
- IDLE
  - If start = 1: load shift register {32'h0, bin_in}, set iteration counter = 0 and busy = 1.
  - Latch ovf_pend = (bin_in > 27'd99_999_999), then go to SHIFT.
  - If start = 0: hold.
- SHIFT, one iteration per cycle for 27 cycles:
  - In the BCD field, add 3 to every nibble ≥ 5.
  - Then shift the whole 59-bit register left by 1.
  - After iteration 27 (counter == 26), go to FORMAT.
- FORMAT, one cycle:
  - If ovf_pend = 1: dsp_data <= 32'hFFFF_FFFF and ovf <= 1.
  - Else if LZ_BLANK = 1: scan from digit 7 down to digit 1 and replace each leading 4'h0 with 4'hF until the first non-zero digit. Digit 0 is never blanked, so value 0 yields 32'hFFFF_FFF0.
  - Else: dsp_data <= raw BCD.
  - Also: ovf <= ovf_pend (when not overflowing), done <= 1, busy <= 0, next state IDLE.
- Overflow inputs still run all 27 SHIFT cycles. Latency does not depend on data; the BCD field simply wraps and is discarded.
- start while busy = 1 is ignored. No queuing and no error flag.
- bin_in changes after the accepting edge have no effect on the running conversion.
- Reset
  - Values: state IDLE, busy 0, done 0, ovf 0, dsp_data 32'hFFFF_FFFF (display fully blank).
  - Reset mid-conversion aborts immediately. No done pulse is issued and the outputs take their reset values.

## Timing
- start is accepted at edge k (state IDLE). busy = 1 from after edge k.
- SHIFT occupies edges k+1..k+27.
- The FORMAT result is registered at edge k+28: done = 1, busy = 0, and dsp_data/ovf are updated for cycle k+28..k+29.
- done falls at edge k+29.
- start sampled high at edge k+29 is accepted, giving a back-to-back throughput of one conversion per 29 cycles.
- done and busy are never high together. done is high for exactly one cycle per accepted start.
- Between done pulses, dsp_data and ovf do not change.

## Test plan
- After reset, check dsp_data = 32'hFFFF_FFFF, busy = 0, done = 0, ovf = 0. Then pulse start with bin_in = 12_345_678 and check:
  - busy rises after the accepting edge;
  - done pulses exactly 28 edges after acceptance;
  - dsp_data = 32'h1234_5678 and ovf = 0.
- LZ_BLANK = 1:
  - bin_in = 0 → dsp_data = 32'hFFFF_FFF0.
  - bin_in = 4096 → 32'hFFFF_4096.
  - bin_in = 10_000_001 → 32'h1000_0001 (interior zeros kept).
- LZ_BLANK = 0: bin_in = 305 → dsp_data = 32'h0000_0305.
- Boundary:
  - bin_in = 99_999_999 → 32'h9999_9999, ovf = 0.
  - bin_in = 100_000_000 → 32'hFFFF_FFFF, ovf = 1.
  - A following conversion of 7 → ovf returns to 0, dsp_data = 32'hFFFF_FFF7.
- Handshake:
  - Hold start high continuously with bin_in changing every cycle. Conversions are accepted only in IDLE, each done reflects the value captured at its accepting edge, and done pulses are spaced 29 cycles apart.
  - Also pulse start mid-conversion: it is ignored.
- Assert bcd_rst for 1 cycle at SHIFT iteration 10. Check:
  - no done pulse;
  - busy = 0 and dsp_data = 32'hFFFF_FFFF the cycle after reset;
  - a new conversion of 42 then completes with 32'hFFFF_FF42.
